bcd_scan_display: RTL and testbench
===================================

Name: bcd_scan_display

Overview:
- Downstream display stage for the BCD digit loader. Takes 4-bit BCD digits on a load strobe and holds the last four in a shift bank.
- Time-multiplexes the four digits onto a common-anode 7-segment display: active-low segments, active-low digit enables.
- Provides blanking of unloaded and leading-zero positions, a dash glyph for non-BCD codes, and a once-per-frame strobe.

Parameters:
- SCAN_DIV, 4, clock cycles each digit slot stays selected (legal ≥1).
- LZ_BLANK, 1, 1 = blank leading zeros in positions 1..3; 0 = show them.

Ports:
- clk  input  1  system clock, rising edge.
- rst_syn  input  1  reset, asynchronous, active-low.
- load_syn  input  1  sampled at rising clk; 1 = shift Din into digit bank.
- clr_syn  input  1  synchronous clear of digit bank and loaded count.
- Din  input  4  BCD digit to load.
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an_n  output  4  digit enables, an_n[0] = rightmost, active-low, registered.
- frame_done  output  1  one-cycle pulse at end of digit-3 slot, registered.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst_syn=0, all of the following hold immediately, with no clock needed:
  - digit bank d0..d3 = 0, loaded count cnt = 0
  - prescaler = 0, scan index idx = 0
  - seg_n = 7'h7F, an_n = 4'hF, frame_done = 0
- Digit bank, evaluated each rising clk:
  - clr_syn=1: d0..d3 <= 0, cnt <= 0. clr_syn has priority over load_syn.
  - else load_syn=1: d3<=d2, d2<=d1, d1<=d0, d0<=Din; cnt <= min(cnt+1, 4).
  - load_syn held high for N cycles performs N loads.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, idx <= (idx+1) mod 4 (order 0,1,2,3,0...).
  - SCAN_DIV=1: idx advances every cycle.
  - clr_syn and load_syn do not disturb the prescaler or idx.
- Output register (1-cycle latency): seg_n and an_n at cycle t+1 are a function of idx, d0..d3, cnt at cycle t.
- Blank condition for position i (i = idx):
  - i ≥ cnt, or
  - LZ_BLANK=1 and i>0 and d_i..d_3 are all zero.
- Blanked slot: an_n = 4'hF, seg_n = 7'h7F.
- Non-blanked slot: an_n = ~(1<<i), seg_n = decode(d_i).
- decode table, seg_n:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - 10..15 = 0111111 (dash, g only)
- Position 0 is never leading-zero blanked, so a loaded 0 shows "0".
- frame_done: registered; high for exactly one cycle after the cycle in which the prescaler wraps with idx=3. Period = 4*SCAN_DIV cycles.
- Reset mid-scan: outputs go to the reset values immediately. After release, scanning restarts at idx=0, prescaler=0.
- Simultaneous clr_syn and load_syn: bank is cleared; Din is discarded.

Test Plan:
- Reset/first load: rst_syn=0 at t=0, release, then load_syn=1 for one cycle with Din=4'b0101 (SCAN_DIV=4).
  - Digit-0 slots: an_n=1110, seg_n=0010010.
  - Slots 1..3: an_n=1111, seg_n=1111111.
  - frame_done pulses every 16 cycles.
- Fill and shift: loads 1,2,3,4 then 9.
  - After fourth load, slots 3..0 show 1,2,3,4.
  - After fifth load, slots show 2,3,4,9; cnt stays 4.
- Invalid code: load 12 → its slot shows seg_n=0111111 with its an_n bit low.
- Leading-zero blanking: loads 0,0,7.
  - LZ_BLANK=1: only slot 0 lit (1111000); slots 1,2 blank.
  - LZ_BLANK=0: slots 1,2 show 1000000.
- Clear priority: load_syn=1 and clr_syn=1 in the same cycle with Din=8 → all slots blank afterwards, cnt=0.
- Async reset mid-scan: drop rst_syn between clock edges during the digit-2 slot.
  - an_n=1111, seg_n=1111111 and frame_done=0 before the next edge.
  - After release, the first lit slot is idx 0 and bank contents are 0.

Source files
------------

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_scan_display
//  Brief    : Four-digit BCD bank scanned onto a common-anode 7-segment display
//  Revision : 1.0
// ============================================================================
module bcd_scan_display #(
    parameter int SCAN_DIV = 4,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_syn,
    input  logic       load_syn,
    input  logic       clr_syn,
    input  logic [3:0] Din,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       frame_done
);

    localparam int                 c_pre_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SCAN_DIV - 1);

    logic [3:0]         r_d [4];
    logic [2:0]         r_cnt;
    logic [c_pre_w-1:0] r_pre;
    logic [1:0]         r_idx;

    logic               w_wrap;
    logic [3:0]         w_digit;
    logic               w_upper_zero;
    logic               w_blank;
    logic [6:0]         w_seg;
    logic [3:0]         w_an;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    // Digit bank: d0 is the newest digit; clear wins over load.
    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            r_d   <= '{default: 4'd0};
            r_cnt <= 3'd0;
        end else if (clr_syn) begin
            r_d   <= '{default: 4'd0};
            r_cnt <= 3'd0;
        end else if (load_syn) begin
            r_d[3] <= r_d[2];
            r_d[2] <= r_d[1];
            r_d[1] <= r_d[0];
            r_d[0] <= Din;
            if (r_cnt != 3'd4) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    assign w_wrap = (r_pre == c_pre_last);

    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            r_pre <= '0;
            r_idx <= 2'd0;
        end else if (w_wrap) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // A slot is blank when not yet loaded, or when it and every more
    // significant digit are zero (position 0 always shows).
    always_comb begin
        w_digit      = r_d[r_idx];
        w_upper_zero = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j >= int'(r_idx) && r_d[j] != 4'd0) begin
                w_upper_zero = 1'b0;
            end
        end
        w_blank = ({1'b0, r_idx} >= r_cnt) ||
                  (LZ_BLANK && (r_idx != 2'd0) && w_upper_zero);
        w_seg   = seg_decode(w_digit);
        w_an    = ~(4'b0001 << r_idx);
    end

    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            seg_n      <= 7'h7F;
            an_n       <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= w_blank ? 7'h7F : w_seg;
            an_n       <= w_blank ? 4'hF : w_an;
            frame_done <= w_wrap && (r_idx == 2'd3);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// Testbench for bcd_scan_display: three configurations checked against a
// cycle model through an expected-value queue.
module tb_bcd_scan_display;

    logic       clk = 1'b0;
    logic       rst_syn = 1'b1;
    logic       load_syn = 1'b0;
    logic       clr_syn = 1'b0;
    logic [3:0] Din = 4'd0;

    logic [6:0] seg0, seg1, seg2;
    logic [3:0] an0, an1, an2;
    logic       fd0, fd1, fd2;
    logic [11:0] obs [3];

    int errors = 0;
    int checks = 0;

    // Model state: shared bank, per-configuration scan state.
    int m_d [4];
    int m_cnt;
    int m_pre [3];
    int m_idx [3];
    int divs [3] = '{4, 4, 1};
    int lzs  [3] = '{1, 0, 1};

    logic [11:0] sb_q [$];

    always #5 clk = ~clk;

    bcd_scan_display #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dut0 (
        .clk(clk), .rst_syn(rst_syn), .load_syn(load_syn), .clr_syn(clr_syn),
        .Din(Din), .seg_n(seg0), .an_n(an0), .frame_done(fd0));
    bcd_scan_display #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) dut1 (
        .clk(clk), .rst_syn(rst_syn), .load_syn(load_syn), .clr_syn(clr_syn),
        .Din(Din), .seg_n(seg1), .an_n(an1), .frame_done(fd1));
    bcd_scan_display #(.SCAN_DIV(1), .LZ_BLANK(1'b1)) dut2 (
        .clk(clk), .rst_syn(rst_syn), .load_syn(load_syn), .clr_syn(clr_syn),
        .Din(Din), .seg_n(seg2), .an_n(an2), .frame_done(fd2));

    assign obs[0] = {seg0, an0, fd0};
    assign obs[1] = {seg1, an1, fd1};
    assign obs[2] = {seg2, an2, fd2};

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [11:0] model_out(input int c);
        int  i;
        bit  blank;
        bit  zeros;
        bit  fd;
        logic [3:0] an;
        i     = m_idx[c];
        blank = (i >= m_cnt);
        if (lzs[c] == 1 && i > 0) begin
            zeros = 1'b1;
            for (int j = i; j < 4; j++) if (m_d[j] != 0) zeros = 1'b0;
            if (zeros) blank = 1'b1;
        end
        fd = (m_pre[c] == divs[c] - 1) && (m_idx[c] == 3);
        case (i)
            0:       an = 4'b1110;
            1:       an = 4'b1101;
            2:       an = 4'b1011;
            default: an = 4'b0111;
        endcase
        if (blank) return {7'h7F, 4'hF, fd};
        return {glyph(m_d[i]), an, fd};
    endfunction

    task automatic model_reset;
        for (int j = 0; j < 4; j++) m_d[j] = 0;
        m_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            m_pre[c] = 0;
            m_idx[c] = 0;
        end
        sb_q.delete();
    endtask

    // Drive one cycle, queue the output expected one edge later, advance model.
    task automatic step(input logic ld, input logic cl, input logic [3:0] din);
        load_syn = ld;
        clr_syn  = cl;
        Din      = din;
        for (int c = 0; c < 3; c++) sb_q.push_back(model_out(c));
        @(posedge clk);
        if (cl) begin
            for (int j = 0; j < 4; j++) m_d[j] = 0;
            m_cnt = 0;
        end else if (ld) begin
            m_d[3] = m_d[2];
            m_d[2] = m_d[1];
            m_d[1] = m_d[0];
            m_d[0] = int'(din);
            if (m_cnt < 4) m_cnt++;
        end
        for (int c = 0; c < 3; c++) begin
            if (m_pre[c] == divs[c] - 1) begin
                m_pre[c] = 0;
                m_idx[c] = (m_idx[c] + 1) % 4;
            end else begin
                m_pre[c]++;
            end
        end
        #1;
        load_syn = 1'b0;
        clr_syn  = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst_syn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== {7'h7F, 4'hF, 1'b0}) begin
                errors++;
                $display("FAIL reset_async dut%0d got=%b want=%b", k, obs[k], {7'h7F, 4'hF, 1'b0});
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== {7'h7F, 4'hF, 1'b0}) begin
                errors++;
                $display("FAIL reset_held dut%0d got=%b want=%b", k, obs[k], {7'h7F, 4'hF, 1'b0});
            end
        end
        rst_syn = 1'b1;
        model_reset();
    endtask

    task automatic test_first_load;
        logic [5:0]  seq [$];
        logic [11:0] exp;
        seq.push_back({2'b10, 4'd5});
        repeat (36) seq.push_back(6'd0);
        for (int n = 0; n < seq.size(); n++) begin
            step(seq[n][5], seq[n][4], seq[n][3:0]);
            for (int k = 0; k < 3; k++) begin
                exp = sb_q.pop_front();
                checks++;
                if (obs[k] !== exp) begin
                    errors++;
                    $display("FAIL first_load dut%0d cyc%0d got=%b want=%b", k, n, obs[k], exp);
                end
            end
        end
        // Literal check of the digit-0 slot pattern once scanning has settled.
        while (m_idx[0] != 0 || m_pre[0] != 1) step(1'b0, 1'b0, 4'd0);
        sb_q.delete();
        checks++;
        if ({seg0, an0} !== {7'b0010010, 4'b1110}) begin
            errors++;
            $display("FAIL first_load_digit0 got seg=%b an=%b want seg=0010010 an=1110", seg0, an0);
        end
    endtask

    task automatic test_fill_shift;
        logic [5:0]  seq [$];
        logic [11:0] exp;
        seq.push_back({2'b01, 4'd0});
        seq.push_back({2'b10, 4'd1});
        seq.push_back({2'b10, 4'd2});
        seq.push_back({2'b10, 4'd3});
        seq.push_back({2'b10, 4'd4});
        repeat (17) seq.push_back(6'd0);
        seq.push_back({2'b10, 4'd9});
        repeat (17) seq.push_back(6'd0);
        for (int n = 0; n < seq.size(); n++) begin
            step(seq[n][5], seq[n][4], seq[n][3:0]);
            for (int k = 0; k < 3; k++) begin
                exp = sb_q.pop_front();
                checks++;
                if (obs[k] !== exp) begin
                    errors++;
                    $display("FAIL fill_shift dut%0d cyc%0d got=%b want=%b", k, n, obs[k], exp);
                end
            end
        end
    endtask

    task automatic test_invalid_code;
        logic [5:0]  seq [$];
        logic [11:0] exp;
        seq.push_back({2'b10, 4'd12});
        repeat (17) seq.push_back(6'd0);
        for (int n = 0; n < seq.size(); n++) begin
            step(seq[n][5], seq[n][4], seq[n][3:0]);
            for (int k = 0; k < 3; k++) begin
                exp = sb_q.pop_front();
                checks++;
                if (obs[k] !== exp) begin
                    errors++;
                    $display("FAIL invalid_code dut%0d cyc%0d got=%b want=%b", k, n, obs[k], exp);
                end
            end
        end
    endtask

    task automatic test_lz_blank;
        logic [5:0]  seq [$];
        logic [11:0] exp;
        seq.push_back({2'b01, 4'd0});
        seq.push_back({2'b10, 4'd0});
        seq.push_back({2'b10, 4'd0});
        seq.push_back({2'b10, 4'd7});
        repeat (18) seq.push_back(6'd0);
        for (int n = 0; n < seq.size(); n++) begin
            step(seq[n][5], seq[n][4], seq[n][3:0]);
            for (int k = 0; k < 3; k++) begin
                exp = sb_q.pop_front();
                checks++;
                if (obs[k] !== exp) begin
                    errors++;
                    $display("FAIL lz_blank dut%0d cyc%0d got=%b want=%b", k, n, obs[k], exp);
                end
            end
        end
    endtask

    task automatic test_clear_priority;
        logic [5:0]  seq [$];
        logic [11:0] exp;
        seq.push_back({2'b11, 4'd8});
        repeat (17) seq.push_back(6'd0);
        for (int n = 0; n < seq.size(); n++) begin
            step(seq[n][5], seq[n][4], seq[n][3:0]);
            for (int k = 0; k < 3; k++) begin
                exp = sb_q.pop_front();
                checks++;
                if (obs[k] !== exp) begin
                    errors++;
                    $display("FAIL clear_priority dut%0d cyc%0d got=%b want=%b", k, n, obs[k], exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0]  seq [$];
        logic [11:0] exp;
        seq.push_back({2'b10, 4'd3});
        seq.push_back({2'b10, 4'd8});
        seq.push_back({2'b10, 4'd1});
        seq.push_back({2'b10, 4'd15});
        seq.push_back({2'b10, 4'd6});
        seq.push_back({2'b10, 4'd2});
        repeat (17) seq.push_back(6'd0);
        for (int n = 0; n < seq.size(); n++) begin
            step(seq[n][5], seq[n][4], seq[n][3:0]);
            for (int k = 0; k < 3; k++) begin
                exp = sb_q.pop_front();
                checks++;
                if (obs[k] !== exp) begin
                    errors++;
                    $display("FAIL back_to_back dut%0d cyc%0d got=%b want=%b", k, n, obs[k], exp);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        logic [5:0]  seq [$];
        logic [11:0] exp;
        int          guard;
        guard = 0;
        while (m_idx[0] != 2 && guard < 20) begin
            step(1'b0, 1'b0, 4'd0);
            guard++;
        end
        sb_q.delete();
        checks++;
        if (m_idx[0] != 2) begin
            errors++;
            $display("FAIL async_reset_reach_slot2 got idx=%0d want idx=2", m_idx[0]);
        end
        rst_syn = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== {7'h7F, 4'hF, 1'b0}) begin
                errors++;
                $display("FAIL async_reset_mid dut%0d got=%b want=%b", k, obs[k], {7'h7F, 4'hF, 1'b0});
            end
        end
        #2 rst_syn = 1'b1;
        model_reset();
        seq.push_back(6'd0);
        seq.push_back({2'b10, 4'd0});
        repeat (18) seq.push_back(6'd0);
        for (int n = 0; n < seq.size(); n++) begin
            step(seq[n][5], seq[n][4], seq[n][3:0]);
            for (int k = 0; k < 3; k++) begin
                exp = sb_q.pop_front();
                checks++;
                if (obs[k] !== exp) begin
                    errors++;
                    $display("FAIL async_reset_after dut%0d cyc%0d got=%b want=%b", k, n, obs[k], exp);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_load();
        test_fill_shift();
        test_invalid_code();
        test_lz_blank();
        test_clear_priority();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
